// File: rtl/spi_pkg.sv
// Shared SPI framing definitions: talker/listener states, widths, header stamp.
package spi_pkg;
    localparam int HDR_W   = 3;
    localparam int BYTE_W  = 8;
    localparam int FRAME_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        B0,
        B1,
        B2
    } state_e;

    function automatic logic [FRAME_W-1:0] stamp_frame(
        input logic [BYTE_W-1:0]  hdr_byte,
        input logic [FRAME_W-1:0] data
    );
        return {hdr_byte[BYTE_W-1 -: HDR_W], data[FRAME_W-HDR_W-1:0]};
    endfunction
endpackage

// File: rtl/spi_gap_timer.sv
// Inter-byte gap counter: counts enabled cycles since clear, flags LIMIT.
module spi_gap_timer #(
    parameter int           W     = 16,
    parameter logic [W-1:0] LIMIT = W'(200)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    logic [W-1:0] count_q, count_d;

    assign hit_o = (count_q == LIMIT);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !hit_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/spi_talker.sv
// Response framer: stamps header, feeds three bytes to the SPI slave,
// keeps one pending word and aborts a frame when the master stalls.
module spi_talker
    import spi_pkg::*;
#(
    parameter logic [BYTE_W-1:0] FIRST_BYTE     = 8'h00,
    parameter logic [BYTE_W-1:0] IDLE_BYTE      = 8'hFF,
    parameter int                TALKER_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_start,
    input  logic               spi_slave_byte_done,
    output logic [BYTE_W-1:0]  spi_tx_byte,
    output logic               tx_busy,
    output logic               tx_pending,
    output logic               tx_done,
    output logic               tx_abort
);
    state_e                  state_q, state_d;
    logic [2*BYTE_W-1:0]     rest_q, rest_d;
    logic [FRAME_W-1:0]      pend_q, pend_d;
    logic                    pv_q, pv_d;
    logic [BYTE_W-1:0]       byte_q, byte_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
    logic [FRAME_W-1:0]      new_frame;
    logic                    busy, gap_run, hit;
    logic                    unused_hdr;

    // Header bits of tx_data are overwritten by the stamp.
    assign unused_hdr = ^tx_data[FRAME_W-1 -: HDR_W];

    assign busy    = (state_q != IDLE);
    assign gap_run = (state_q == B1) || (state_q == B2);

    spi_gap_timer #(
        .W     (16),
        .LIMIT (16'(TALKER_TIMEOUT))
    ) u_gap (
        .clk   (clk),
        .rst   (rst),
        .clr_i (spi_slave_byte_done || !gap_run),
        .en_i  (gap_run),
        .hit_o (hit)
    );

    always_comb begin
        state_d   = state_q;
        rest_d    = rest_q;
        pend_d    = pend_q;
        pv_d      = pv_q;
        byte_d    = byte_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        new_frame = stamp_frame(FIRST_BYTE, tx_data);

        if (busy && tx_start && !pv_q) begin
            pend_d = new_frame;
            pv_d   = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                byte_d = IDLE_BYTE;
                if (pv_q) begin
                    {byte_d, rest_d} = pend_q;
                    pv_d             = 1'b0;
                    state_d          = B0;
                end else if (tx_start) begin
                    {byte_d, rest_d} = new_frame;
                    state_d          = B0;
                end
            end
            B0: begin
                if (spi_slave_byte_done) begin
                    byte_d  = rest_q[2*BYTE_W-1:BYTE_W];
                    state_d = B1;
                end
            end
            B1: begin
                if (spi_slave_byte_done) begin
                    byte_d  = rest_q[BYTE_W-1:0];
                    state_d = B2;
                end else if (hit) begin
                    byte_d  = IDLE_BYTE;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            B2: begin
                if (spi_slave_byte_done) begin
                    done_d = 1'b1;
                    // A word arriving on the final byte skips the slot.
                    if (pv_q) begin
                        {byte_d, rest_d} = pend_q;
                        pv_d             = 1'b0;
                        state_d          = B0;
                    end else if (tx_start) begin
                        {byte_d, rest_d} = new_frame;
                        pv_d             = 1'b0;
                        state_d          = B0;
                    end else begin
                        byte_d  = IDLE_BYTE;
                        state_d = IDLE;
                    end
                end else if (hit) begin
                    byte_d  = IDLE_BYTE;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rest_q  <= '0;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            byte_q  <= IDLE_BYTE;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rest_q  <= rest_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign spi_tx_byte = byte_q;
    assign tx_busy     = busy;
    assign tx_pending  = pv_q;
    assign tx_done     = done_q;
    assign tx_abort    = abort_q;
endmodule

// File: tb/tb_spi_talker.sv
// Directed bench for spi_talker: vector table plus timeout/reset/pending
// sequences, all expected bytes hand-derived with header 3'b010.
module tb_spi_talker;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tx_data;
    logic        tx_start;
    logic        bd;
    logic [7:0]  spi_tx_byte;
    logic        tx_busy, tx_pending, tx_done, tx_abort;

    int errors = 0;
    int checks = 0;

    spi_talker #(
        .FIRST_BYTE     (8'h40),
        .IDLE_BYTE      (8'hFF),
        .TALKER_TIMEOUT (200)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .tx_data             (tx_data),
        .tx_start            (tx_start),
        .spi_slave_byte_done (bd),
        .spi_tx_byte         (spi_tx_byte),
        .tx_busy             (tx_busy),
        .tx_pending          (tx_pending),
        .tx_done             (tx_done),
        .tx_abort            (tx_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [23:0] data;
        logic        bd;
        logic [7:0]  e_byte;
        logic        e_busy;
        logic        e_pend;
        logic        e_done;
        logic        e_abort;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] b,
                           input logic busy, input logic pend,
                           input logic done, input logic abort);
        chk({name, ".byte"}, 32'(spi_tx_byte), 32'(b));
        chk({name, ".busy"}, 32'(tx_busy), 32'(busy));
        chk({name, ".pend"}, 32'(tx_pending), 32'(pend));
        chk({name, ".done"}, 32'(tx_done), 32'(done));
        chk({name, ".abort"}, 32'(tx_abort), 32'(abort));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        bd       = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start(input logic [23:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
    endtask

    task automatic pulse();
        bd = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 24'h0,      0, 8'hFF, 0, 0, 0, 0};
        vt[1]  = '{1, 24'hABCDEF, 0, 8'h4B, 1, 0, 0, 0};
        vt[2]  = '{0, 24'h0,      0, 8'h4B, 1, 0, 0, 0};
        vt[3]  = '{0, 24'h0,      1, 8'hCD, 1, 0, 0, 0};
        vt[4]  = '{0, 24'h0,      1, 8'hEF, 1, 0, 0, 0};
        vt[5]  = '{0, 24'h0,      1, 8'hFF, 0, 0, 1, 0};
        vt[6]  = '{0, 24'h0,      0, 8'hFF, 0, 0, 0, 0};
        vt[7]  = '{1, 24'h000001, 0, 8'h40, 1, 0, 0, 0};
        vt[8]  = '{1, 24'h000002, 0, 8'h40, 1, 1, 0, 0};
        vt[9]  = '{1, 24'h000003, 0, 8'h40, 1, 1, 0, 0};
        vt[10] = '{0, 24'h0,      1, 8'h00, 1, 1, 0, 0};
        vt[11] = '{0, 24'h0,      1, 8'h01, 1, 1, 0, 0};
        vt[12] = '{0, 24'h0,      1, 8'h40, 1, 0, 1, 0};
        vt[13] = '{0, 24'h0,      1, 8'h00, 1, 0, 0, 0};
        vt[14] = '{0, 24'h0,      1, 8'h02, 1, 0, 0, 0};
        vt[15] = '{1, 24'h123456, 1, 8'h52, 1, 0, 1, 0};
        vt[16] = '{0, 24'h0,      1, 8'h34, 1, 0, 0, 0};
        vt[17] = '{0, 24'h0,      1, 8'h56, 1, 0, 0, 0};
        vt[18] = '{0, 24'h0,      1, 8'hFF, 0, 0, 1, 0};
        vt[19] = '{0, 24'h0,      1, 8'hFF, 0, 0, 0, 0};

        rst = 1'b1; tx_data = '0; tx_start = 1'b0; bd = 1'b0;
        tick();
        tick();
        chk_all("reset", 8'hFF, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tx_start = vt[i].start;
            tx_data  = vt[i].data;
            bd       = vt[i].bd;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].e_byte, vt[i].e_busy,
                    vt[i].e_pend, vt[i].e_done, vt[i].e_abort);
        end

        // Spaced byte_done pulses, 10 cycles apart.
        start(24'hABCDEF);
        chk_all("gap.b0", 8'h4B, 1, 0, 0, 0);
        idle(9); pulse();
        chk_all("gap.b1", 8'hCD, 1, 0, 0, 0);
        idle(9); pulse();
        chk_all("gap.b2", 8'hEF, 1, 0, 0, 0);
        idle(9); pulse();
        chk_all("gap.end", 8'hFF, 0, 0, 1, 0);
        tick();
        chk_all("gap.after", 8'hFF, 0, 0, 0, 0);

        // Stall in B1 reaches the limit.
        start(24'hABCDEF); pulse();
        idle(199);
        chk_all("to.199", 8'hCD, 1, 0, 0, 0);
        tick();
        chk_all("to.200", 8'hCD, 1, 0, 0, 0);
        tick();
        chk_all("to.abort", 8'hFF, 0, 0, 0, 1);
        tick();
        chk_all("to.post", 8'hFF, 0, 0, 0, 0);

        // byte_done on the hit cycle wins.
        start(24'hABCDEF); pulse();
        idle(200);
        pulse();
        chk_all("race.b2", 8'hEF, 1, 0, 0, 0);
        tick(); pulse();
        chk_all("race.end", 8'hFF, 0, 0, 1, 0);

        // Pending word survives an abort and launches next cycle.
        start(24'hABCDEF);
        start(24'h000002);
        pulse();
        idle(201);
        chk_all("surv.abort", 8'hFF, 0, 1, 0, 1);
        tick();
        chk_all("surv.launch", 8'h40, 1, 0, 0, 0);
        pulse(); pulse(); pulse();
        chk_all("surv.end", 8'hFF, 0, 0, 1, 0);

        // Reset mid-frame with a pending word.
        start(24'hABCDEF);
        start(24'h000001);
        pulse();
        chk_all("rst.pre", 8'hCD, 1, 1, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst.now", 8'hFF, 0, 0, 0, 0);
        pulse();
        chk_all("rst.bd", 8'hFF, 0, 0, 0, 0);
        tick();
        chk_all("rst.quiet", 8'hFF, 0, 0, 0, 0);

        // Long idle stretch with stray byte_done pulses.
        begin
            int bad = 0;
            for (int i = 0; i < 10000; i++) begin
                bd = (i % 7 == 0);
                tick();
                if (spi_tx_byte !== 8'hFF || tx_done !== 1'b0 ||
                    tx_abort !== 1'b0 || tx_busy !== 1'b0)
                    bad++;
            end
            chk("idle10k.bad_cycles", 32'(bad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
